fifo_byte_serializer: RTL and testbench

Downstream drain stage for sync_fifo. Pops 32-bit words from the FIFO read port using rn, DATAOUT and empty, then emits each word as four 8-bit bytes on a valid/ready byte stream. Feeds the narrow byte-wide link or UART-style consumer that follows the buffering stage. Keeps a running count of fully transmitted words for status and debug.

---
 rtl/fifo_byte_serializer.sv | 110 +++++++++++
 tb/tb_fifo_byte_serializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
//
// Drain stage for a synchronous FIFO. It pops one DATA_W-bit word at a time
// through the FIFO read port and sends it as DATA_W/BYTE_W bytes on a
// valid/ready byte stream. It also counts the words whose last byte was
// accepted.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after fifo_rn
//   fifo_rn     FIFO read enable, one-cycle pulse per word
//   byte_out    current output byte (0 when not valid)
//   byte_valid  byte_out holds a valid byte
//   byte_ready  consumer accepts byte_out on an edge with byte_valid=1
//   busy        high whenever the FSM is not idle
//   words_sent  count of fully accepted words, wraps modulo 2^CNT_W
module fifo_byte_serializer #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rn,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {IDLE, POP, CAPT, SEND} state_t;

  state_t             state_reg, state_next;
  logic               rn_reg;
  logic [DATA_W-1:0]  word_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BYTE_W-1:0]  byte_lane [NB];

  // Byte lanes are numbered in transmission order, so lane 0 is the first
  // byte on the wire regardless of MSB_FIRST.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    if (MSB_FIRST != 0) begin : g_msb
      assign byte_lane[gi] = word_reg[DATA_W-1-gi*BYTE_W -: BYTE_W];
    end else begin : g_lsb
      assign byte_lane[gi] = word_reg[gi*BYTE_W +: BYTE_W];
    end
  end

  wire last_accept = (state_reg == SEND) && byte_ready && (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    byte_valid = 1'b0;
    byte_out   = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (!fifo_empty) state_next = POP;
      POP:  state_next = CAPT;
      CAPT: state_next = SEND;
      SEND: begin
        byte_valid = 1'b1;
        byte_out   = byte_lane[idx_reg];
        // Going straight to POP only when the FIFO reports data keeps the
        // read strictly behind a sampled non-empty flag.
        if (last_accept) state_next = fifo_empty ? IDLE : POP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rn_reg    <= 1'b0;
      word_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Registered copy of "in POP" so fifo_rn comes straight from a flop.
      rn_reg    <= (state_next == POP);
      if (state_reg == CAPT) begin
        word_reg <= fifo_dout;
        idx_reg  <= '0;
      end
      if (state_reg == SEND && byte_ready) begin
        if (idx_reg == LAST_IDX) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign fifo_rn    = rn_reg;
  assign words_sent = cnt_reg;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
module tb_fifo_byte_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        byte_ready;

  // instance 1: MSB first, 16-bit counter
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout  = '0;
  logic        fifo_rn;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        busy;
  logic [15:0] words_sent;

  // instance 2: LSB first, 2-bit counter
  logic        fifo_empty2 = 1'b1;
  logic [31:0] fifo_dout2  = '0;
  logic        fifo_rn2;
  logic [7:0]  byte_out2;
  logic        byte_valid2;
  logic        busy2;
  logic [1:0]  words_sent2;

  int total = 0;
  int bad   = 0;

  logic [31:0] fq[$];
  logic [31:0] fq2[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp2_q[$];

  int cyc = 0;
  int rn_cnt = 0, rn_cyc = 0, acc_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic rn_prev = 1'b0;
  logic hold_pending = 1'b0;
  logic [7:0] hold_byte = '0;

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rn(fifo_rn), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .words_sent(words_sent));

  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
    .fifo_rn(fifo_rn2), .byte_out(byte_out2), .byte_valid(byte_valid2),
    .byte_ready(byte_ready), .busy(busy2), .words_sent(words_sent2));

  always #5 clock = ~clock;

  // FIFO models: DATAOUT advances at the edge ending a read cycle, the empty
  // flag reflects contents as of each edge.
  always @(posedge clock) begin
    if (fifo_rn && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  always @(posedge clock) begin
    if (fifo_rn2 && fq2.size() > 0) fifo_dout2 <= fq2.pop_front();
    fifo_empty2 <= (fq2.size() == 0);
  end

  // Monitor for instance 1: scoreboard pop on each accepted byte, plus
  // read-pulse and stall-stability checks.
  always @(negedge clock) begin
    logic [7:0] e;
    cyc++;
    if (reset) begin
      if (fifo_rn) begin
        total++;
        if (fifo_empty !== 1'b0 || rn_prev !== 1'b0) begin
          bad++;
          $display("FAIL rn_pulse: empty=%0b prev_rn=%0b required empty=0 prev_rn=0", fifo_empty, rn_prev);
        end
        rn_cnt++;
        rn_cyc = cyc;
      end
      rn_prev = fifo_rn;
      if (hold_pending) begin
        total++;
        if (byte_valid !== 1'b1 || byte_out !== hold_byte) begin
          bad++;
          $display("FAIL hold: valid=%0b byte=%02h required valid=1 byte=%02h", byte_valid, byte_out, hold_byte);
        end
      end
      hold_pending = byte_valid && !byte_ready;
      hold_byte    = byte_out;
      if (byte_valid && byte_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL byte1: got %02h required none", byte_out);
        end else begin
          e = exp_q.pop_front();
          if (byte_out !== e) begin
            bad++;
            $display("FAIL byte1: got %02h required %02h", byte_out, e);
          end else begin
            $display("byte1 %02h ok", byte_out);
          end
        end
        if (acc_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        acc_cnt++;
      end
    end else begin
      rn_prev      = 1'b0;
      hold_pending = 1'b0;
    end
  end

  // Monitor for instance 2
  always @(negedge clock) begin
    logic [7:0] e;
    if (reset) begin
      if (fifo_rn2) begin
        total++;
        if (fifo_empty2 !== 1'b0) begin
          bad++;
          $display("FAIL rn_empty2: empty=%0b required 0", fifo_empty2);
        end
      end
      if (byte_valid2 && byte_ready) begin
        total++;
        if (exp2_q.size() == 0) begin
          bad++;
          $display("FAIL byte2: got %02h required none", byte_out2);
        end else begin
          e = exp2_q.pop_front();
          if (byte_out2 !== e) begin
            bad++;
            $display("FAIL byte2: got %02h required %02h", byte_out2, e);
          end else begin
            $display("byte2 %02h ok", byte_out2);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("%s %0h ok", name, act);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
  endtask

  task automatic push_word2(input logic [31:0] w);
    fq2.push_back(w);
    for (int i = 0; i < 4; i++) exp2_q.push_back(w[8*i +: 8]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drained(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && fq.size() == 0 && busy == 1'b0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_drained2(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp2_q.size() == 0 && fq2.size() == 0 && busy2 == 1'b0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic clr_stats();
    acc_cnt = 0;
    rn_cnt  = 0;
  endtask

  initial begin
    logic [7:0] pat;
    logic       seen;
    reset = 1'b0;
    byte_ready = 1'b0;
    repeat (3) tick();
    chk("rst_fifo_rn", 32'(fifo_rn), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_sent), 32'd0);
    reset = 1'b1;
    tick();

    // 1: single word, consumer always ready
    byte_ready = 1'b1;
    clr_stats();
    push_word(32'h0A0B0C0D);
    wait_drained("t1_drain", 50);
    chk("t1_words", 32'(words_sent), 32'd1);
    chk("t1_rn_pulses", 32'(rn_cnt), 32'd1);
    chk("t1_span", 32'(last_cyc - first_cyc), 32'd3);
    chk("t1_latency", 32'(first_cyc - rn_cyc), 32'd2);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: same word with consumer stalls
    byte_ready = 1'b0;
    clr_stats();
    push_word(32'h0A0B0C0D);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = byte_valid;
    end
    chk("t2_valid_seen", 32'(seen), 32'd1);
    pat = 8'b0010_1101;
    for (int i = 0; i < 8; i++) begin
      byte_ready = pat[7-i];
      tick();
    end
    byte_ready = 1'b1;
    wait_drained("t2_drain", 50);
    chk("t2_words", 32'(words_sent), 32'd2);
    chk("t2_rn_pulses", 32'(rn_cnt), 32'd1);
    chk("t2_bytes", 32'(acc_cnt), 32'd4);

    // 3: seven words back to back
    clr_stats();
    push_word(32'd10); push_word(32'd15); push_word(32'd20); push_word(32'd30);
    push_word(32'd35); push_word(32'd40); push_word(32'd45);
    wait_drained("t3_drain", 200);
    chk("t3_words", 32'(words_sent), 32'd9);
    chk("t3_rn_pulses", 32'(rn_cnt), 32'd7);
    chk("t3_bytes", 32'(acc_cnt), 32'd28);
    chk("t3_span", 32'(last_cyc - first_cyc), 32'd39);

    // 4: empty FIFO stays idle
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_idle", {29'd0, fifo_rn, byte_valid, busy}, 32'd0);
    end

    // 5: asynchronous reset mid-word
    clr_stats();
    push_word(32'hDEADBEEF);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = (acc_cnt >= 2);
    end
    chk("t5_two_bytes", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_out", {fifo_rn, byte_valid, busy, byte_out, words_sent}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_stay_idle", {30'd0, busy, fifo_rn}, 32'd0);
    end
    push_word(32'h11223344);
    wait_drained("t5_drain", 50);
    chk("t5_words", 32'(words_sent), 32'd1);

    // 6: LSB-first instance with 2-bit counter wrap
    push_word2(32'h0A0B0C0D);
    wait_drained2("t6_drain_a", 50);
    chk("t6_words_a", 32'(words_sent2), 32'd1);
    push_word2(32'h01020304); push_word2(32'hA1B2C3D4); push_word2(32'h55667788);
    wait_drained2("t6_drain_b", 100);
    chk("t6_words_wrap", 32'(words_sent2), 32'd0);
    push_word2(32'hCAFEF00D);
    wait_drained2("t6_drain_c", 50);
    chk("t6_words_c", 32'(words_sent2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
